// File: rtl/iram_arbiter_if.sv
// Requester-side bus for the internal work RAM arbiter: command, accept
// strobe and tagged read return for one requester (CPU or DMA).
interface iram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (output req, we, addr, wdata, input ack, rdata, rvalid);
  modport slave  (input req, we, addr, wdata, output ack, rdata, rvalid);
endinterface

// File: rtl/iram_arbiter.sv
// Shares the single-port internal work RAM between CPU and DMA requesters.
// Define IRAM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is DMA-over-CPU.
//
// owner state | meaning
// OWN_NONE    | no access issued to the RAM this cycle
// OWN_CPU     | CPU command on the RAM pins this cycle
// OWN_DMA     | DMA command on the RAM pins this cycle
module iram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  iram_arbiter_if.slave     cpu,
  iram_arbiter_if.slave     dma,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

  owner_t            owner_q, owner_d;
  logic              cpu_ack_q, dma_ack_q;
  logic              cpu_rvalid_q, dma_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
  logic              cpu_elig, dma_elig;
  logic              grant_cpu, grant_dma;

`ifdef IRAM_ARB_ROUND_ROBIN_EN
  logic              last_dma_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // A requester is ineligible in its own ack cycle so the held command is not issued twice.
  always_comb begin
    cpu_elig  = cpu.req & ~cpu_ack_q;
    dma_elig  = dma.req & ~dma_ack_q;
`ifdef IRAM_ARB_ROUND_ROBIN_EN
    grant_dma = dma_elig & (~cpu_elig | ~last_dma_q);
`else
    grant_dma = dma_elig;
`endif
    grant_cpu = cpu_elig & ~grant_dma;
    owner_d   = OWN_NONE;
    if (grant_dma) begin
      owner_d = OWN_DMA;
    end else if (grant_cpu) begin
      owner_d = OWN_CPU;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ram_address  <= '0;
      ram_data     <= '0;
      ram_wren     <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      cpu_ack_q <= grant_cpu;
      dma_ack_q <= grant_dma;
      ram_wren  <= 1'b0;
      if (grant_dma) begin
        ram_address <= dma.addr;
        ram_data    <= dma.wdata;
        ram_wren    <= dma.we;
      end else if (grant_cpu) begin
        ram_address <= cpu.addr;
        ram_data    <= cpu.wdata;
        ram_wren    <= cpu.we;
      end
      // Read issued last cycle returns on ram_q this cycle.
      cpu_rvalid_q <= (owner_q == OWN_CPU) && !ram_wren;
      dma_rvalid_q <= (owner_q == OWN_DMA) && !ram_wren;
      if (cpu_rvalid_q) cpu_rdata_q <= ram_q;
      if (dma_rvalid_q) dma_rdata_q <= ram_q;
    end
  end

`ifdef IRAM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_dma_q <= 1'b0;
    end else if (grant_cpu || grant_dma) begin
      last_dma_q <= grant_dma;
    end
  end
`endif

  assign cpu.ack    = cpu_ack_q;
  assign dma.ack    = dma_ack_q;
  assign cpu.rvalid = cpu_rvalid_q;
  assign dma.rvalid = dma_rvalid_q;
  // Pass ram_q straight through on the return cycle, then hold it.
  assign cpu.rdata  = cpu_rvalid_q ? ram_q : cpu_rdata_q;
  assign dma.rdata  = dma_rvalid_q ? ram_q : dma_rdata_q;

endmodule

// File: tb/tb_iram_arbiter.sv
// Directed bench for iram_arbiter with a synchronous single-port RAM model.
module tb_iram_arbiter;

`ifdef IRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] ram_address;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic [7:0]  ram_q = 8'h00;
  logic [7:0]  mem [0:8191];

  int n_checks = 0;
  int n_errors = 0;
  int dma_n, cpu_n, rv_total;

  iram_arbiter_if #(.ADDR_W(13), .DATA_W(8)) cpu_if ();
  iram_arbiter_if #(.ADDR_W(13), .DATA_W(8)) dma_if ();

  iram_arbiter #(.ADDR_W(13), .DATA_W(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cpu         (cpu_if),
    .dma         (dma_if),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    cpu_if.req = 0; cpu_if.we = 0; cpu_if.addr = 0; cpu_if.wdata = 0;
    dma_if.req = 0; dma_if.we = 0; dma_if.addr = 0; dma_if.wdata = 0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // reset state
    check("rst_wren", ram_wren, 0);
    check("rst_addr", ram_address, 0);
    check("rst_data", ram_data, 0);
    check("rst_cpu_ack", cpu_if.ack, 0);
    check("rst_dma_ack", dma_if.ack, 0);
    check("rst_cpu_rv", cpu_if.rvalid, 0);
    check("rst_cpu_rdata", cpu_if.rdata, 0);
    tick();

    // CPU write then read of 0x1234
    cpu_if.req = 1; cpu_if.we = 1; cpu_if.addr = 13'h1234; cpu_if.wdata = 8'hA5;
    tick();
    check("t1_wr_ack", cpu_if.ack, 1);
    check("t1_wr_wren", ram_wren, 1);
    check("t1_wr_addr", ram_address, 13'h1234);
    check("t1_wr_data", ram_data, 8'hA5);
    check("t1_dma_ack", dma_if.ack, 0);
    cpu_if.req = 0;
    tick();
    check("t1_idle_ack", cpu_if.ack, 0);
    check("t1_idle_wren", ram_wren, 0);
    check("t1_wr_no_rv", cpu_if.rvalid, 0);
    cpu_if.req = 1; cpu_if.we = 0;
    tick();
    check("t1_rd_ack", cpu_if.ack, 1);
    check("t1_rd_wren", ram_wren, 0);
    check("t1_rd_addr", ram_address, 13'h1234);
    cpu_if.req = 0;
    tick();
    check("t1_rd_rv", cpu_if.rvalid, 1);
    check("t1_rd_rdata", cpu_if.rdata, 8'hA5);
    check("t1_dma_rv", dma_if.rvalid, 0);
    tick();
    check("t1_rv_pulse", cpu_if.rvalid, 0);
    check("t1_rdata_hold", cpu_if.rdata, 8'hA5);
    check("t1_dma_rdata", dma_if.rdata, 0);

    // simultaneous reads, DMA wins
    mem[16] = 8'h11; mem[32] = 8'h22;
    cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 13'h0010;
    dma_if.req = 1; dma_if.we = 0; dma_if.addr = 13'h0020;
    tick();
    check("t2_dma_ack", dma_if.ack, 1);
    check("t2_cpu_wait", cpu_if.ack, 0);
    check("t2_addr_dma", ram_address, 13'h0020);
    dma_if.req = 0;
    tick();
    check("t2_cpu_ack", cpu_if.ack, 1);
    check("t2_dma_ack0", dma_if.ack, 0);
    check("t2_addr_cpu", ram_address, 13'h0010);
    check("t2_dma_rv", dma_if.rvalid, 1);
    check("t2_dma_rdata", dma_if.rdata, 8'h22);
    cpu_if.req = 0;
    tick();
    check("t2_cpu_rv", cpu_if.rvalid, 1);
    check("t2_cpu_rdata", cpu_if.rdata, 8'h11);
    check("t2_dma_rv0", dma_if.rvalid, 0);
    tick();

    // both requesters stream 8 reads each
    for (int i = 0; i < 8; i++) begin
      mem[13'h100 + i] = 8'h40 + 8'(i);
      mem[13'h200 + i] = 8'h80 + 8'(i);
    end
    dma_n = 0; cpu_n = 0; rv_total = 0;
    cpu_if.req = 1; cpu_if.addr = 13'h100;
    dma_if.req = 1; dma_if.addr = 13'h200;
    for (int k = 1; k <= 18; k++) begin
      tick();
      check("t3_dma_ack", dma_if.ack, (k <= 16 && k % 2 == 1) ? 1 : 0);
      check("t3_cpu_ack", cpu_if.ack, (k <= 16 && k % 2 == 0) ? 1 : 0);
      if (k <= 16)
        check("t3_addr", ram_address, (k % 2 == 1) ? 13'h200 + (k - 1) / 2 : 13'h100 + (k / 2 - 1));
      check("t3_dma_rv", dma_if.rvalid, (k >= 2 && k <= 17 && k % 2 == 0) ? 1 : 0);
      check("t3_cpu_rv", cpu_if.rvalid, (k >= 3 && k <= 17 && k % 2 == 1) ? 1 : 0);
      if (dma_if.rvalid) begin
        rv_total++;
        check("t3_dma_rdata", dma_if.rdata, 8'h80 + (k - 2) / 2);
      end
      if (cpu_if.rvalid) begin
        rv_total++;
        check("t3_cpu_rdata", cpu_if.rdata, 8'h40 + (k - 3) / 2);
      end
      if (dma_if.ack) begin
        dma_n++;
        if (dma_n == 8) dma_if.req = 0; else dma_if.addr = 13'(13'h200 + dma_n);
      end
      if (cpu_if.ack) begin
        cpu_n++;
        if (cpu_n == 8) cpu_if.req = 0; else cpu_if.addr = 13'(13'h100 + cpu_n);
      end
    end
    check("t3_rv_total", rv_total, 16);

    // DMA write then CPU read of the same address
    dma_if.req = 1; dma_if.we = 1; dma_if.addr = 13'h1FFF; dma_if.wdata = 8'h3C;
    cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 13'h1FFF;
    tick();
    check("t4_dma_ack", dma_if.ack, 1);
    check("t4_wren", ram_wren, 1);
    dma_if.req = 0;
    tick();
    check("t4_cpu_ack", cpu_if.ack, 1);
    check("t4_rd_addr", ram_address, 13'h1FFF);
    cpu_if.req = 0;
    tick();
    check("t4_cpu_rv", cpu_if.rvalid, 1);
    check("t4_raw_data", cpu_if.rdata, 8'h3C);
    tick();

    // reset while a CPU read is in flight
    cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 13'h0010;
    tick();
    check("t5_ack", cpu_if.ack, 1);
    cpu_if.req = 0;
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_ack", cpu_if.ack, 0);
    check("t5_async_addr", ram_address, 0);
    check("t5_async_rdata", cpu_if.rdata, 0);
    tick();
    check("t5_no_rv_rst", cpu_if.rvalid, 0);
    reset_n = 1'b1;
    tick();
    check("t5_no_rv", cpu_if.rvalid, 0);
    check("t5_wren", ram_wren, 0);

    // reset during a DMA write: wren drops without a clock edge
    dma_if.req = 1; dma_if.we = 1; dma_if.addr = 13'h0050; dma_if.wdata = 8'h77;
    tick();
    check("t5b_wren_on", ram_wren, 1);
    dma_if.req = 0; dma_if.we = 0;
    #2 reset_n = 1'b0;
    #1;
    check("t5b_async_wren", ram_wren, 0);
    check("t5b_async_ack", dma_if.ack, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // tie-break after a CPU grant: DMA wins in both modes
    cpu_if.req = 1; cpu_if.we = 0; cpu_if.addr = 13'h0010;
    tick();
    check("t6a_pre_ack", cpu_if.ack, 1);
    cpu_if.req = 0;
    tick();
    cpu_if.req = 1; dma_if.req = 1; dma_if.we = 0; dma_if.addr = 13'h0020;
    tick();
    check("t6a_dma_win", dma_if.ack, 1);
    check("t6a_cpu_lose", cpu_if.ack, 0);
    dma_if.req = 0;
    tick();
    check("t6a_cpu_next", cpu_if.ack, 1);
    cpu_if.req = 0;
    tick();
    tick();

    // tie-break after a DMA grant: CPU wins only with round-robin
    dma_if.req = 1;
    tick();
    check("t6b_pre_ack", dma_if.ack, 1);
    dma_if.req = 0;
    tick();
    cpu_if.req = 1; dma_if.req = 1;
    tick();
    check("t6b_cpu_win", cpu_if.ack, RR_EN ? 1 : 0);
    check("t6b_dma_win", dma_if.ack, RR_EN ? 0 : 1);
    if (cpu_if.ack) cpu_if.req = 0;
    if (dma_if.ack) dma_if.req = 0;
    tick();
    check("t6b_cpu_next", cpu_if.ack, RR_EN ? 0 : 1);
    check("t6b_dma_next", dma_if.ack, RR_EN ? 1 : 0);
    cpu_if.req = 0; dma_if.req = 0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
